// File: rtl/hall_spin_ctrl_pkg.sv
// Shared types and constants for the Hall-plate spinning-current sequencer.
package hall_spin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWITCH  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } spin_state_e;

  // Bit set = the reading of that phase is subtracted from the sum.
  localparam logic [3:0] SPIN_SIGN  = 4'b1010;
  localparam logic [3:0] PHASE_IDLE = 4'b0000;

  // One-hot bias phase for a 2-bit phase index.
  function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
    logic [3:0] ph;
    case (idx)
      2'd0:    ph = 4'b0001;
      2'd1:    ph = 4'b0010;
      2'd2:    ph = 4'b0100;
      2'd3:    ph = 4'b1000;
      default: ph = 4'b0000;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/hall_spin_ctrl_if.sv
// ADC start/done handshake between the sequencer (master) and the converter (slave).
interface hall_spin_ctrl_if #(
  parameter int ADC_W = 12
) ();
  logic                    adc_start;
  logic                    adc_done;
  logic signed [ADC_W-1:0] adc_data;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data
  );
endinterface

// File: rtl/hall_spin_ctrl_timer.sv
// Loadable down-counter; terminal flags the last counted cycle (count == 1).
module hall_spin_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] load_val,
  output logic             terminal
);

  logic [CNT_W-1:0] count_r;

  // Load has priority; otherwise count down while running and hold at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (run && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == CNT_W'(1));

endmodule

// File: rtl/hall_spin_ctrl.sv
// Spinning-current sequencer: steps the four bias phases, runs one ADC
// conversion per phase and forms the offset-cancelled Hall sum.
module hall_spin_ctrl
  import hall_spin_pkg::*;
#(
  parameter int ADC_W   = 12,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    continuous,
  input  logic [CNT_W-1:0]        settle_cycles,
  output logic [3:0]              phases,
  output logic                    phases_update,
  hall_spin_ctrl_if.master        adc,
  output logic signed [ADC_W+1:0] result,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_SWITCH  = ST_SWITCH;
  localparam logic [2:0] S_SETTLE  = ST_SETTLE;
  localparam logic [2:0] S_CONVERT = ST_CONVERT;
  localparam logic [2:0] S_NEXT    = ST_NEXT;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]              state_r;
  logic [1:0]              idx_r;
  logic signed [ADC_W+1:0] acc_r;
  logic                    enable_q_r;
  logic [3:0]              phases_r;
  logic                    phases_update_r;
  logic                    adc_start_r;
  logic signed [ADC_W+1:0] result_r;
  logic                    result_valid_r;
  logic                    busy_r;
  logic                    timeout_err_r;

  logic [2:0]              state_nxt_s;
  logic [1:0]              idx_nxt_s;
  logic signed [ADC_W+1:0] acc_nxt_s;
  logic [3:0]              phases_nxt_s;
  logic                    phases_update_nxt_s;
  logic                    adc_start_nxt_s;
  logic signed [ADC_W+1:0] result_nxt_s;
  logic                    result_valid_nxt_s;
  logic                    timeout_err_nxt_s;
  logic                    settle_load_s;
  logic                    tmo_load_s;
  logic                    settle_term_s;
  logic                    tmo_term_s;
  logic [CNT_W-1:0]        settle_val_s;
  logic signed [ADC_W+1:0] sample_s;
  logic                    start_req_s;

  // A settle time of zero still spends one cycle in SETTLE.
  assign settle_val_s = (settle_cycles == {CNT_W{1'b0}}) ? CNT_W'(1) : settle_cycles;
  assign sample_s     = {{2{adc.adc_data[ADC_W-1]}}, adc.adc_data};
  // A latched timeout blocks every start until enable is toggled.
  assign start_req_s  = (~enable_q_r | continuous) & ~timeout_err_r;

  hall_spin_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load_s),
    .run      (state_r == S_SETTLE),
    .load_val (settle_val_s),
    .terminal (settle_term_s)
  );

  hall_spin_timer #(.CNT_W(CNT_W)) u_tmo_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmo_load_s),
    .run      (state_r == S_CONVERT),
    .load_val (CNT_W'(TIMEOUT)),
    .terminal (tmo_term_s)
  );

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_nxt_s         = state_r;
    idx_nxt_s           = idx_r;
    acc_nxt_s           = acc_r;
    phases_nxt_s        = phases_r;
    phases_update_nxt_s = 1'b0;
    adc_start_nxt_s     = 1'b0;
    result_nxt_s        = result_r;
    result_valid_nxt_s  = 1'b0;
    timeout_err_nxt_s   = timeout_err_r;
    settle_load_s       = 1'b0;
    tmo_load_s          = 1'b0;

    if (!enable) begin
      // Abort: drop the plate bias, discard the partial sum, clear the error.
      state_nxt_s       = S_IDLE;
      idx_nxt_s         = 2'd0;
      acc_nxt_s         = {(ADC_W+2){1'b0}};
      phases_nxt_s      = PHASE_IDLE;
      timeout_err_nxt_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_req_s) begin
            state_nxt_s = S_SWITCH;
            idx_nxt_s   = 2'd0;
            acc_nxt_s   = {(ADC_W+2){1'b0}};
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_SWITCH: begin
          phases_nxt_s        = phase_onehot(idx_r);
          phases_update_nxt_s = 1'b1;
          settle_load_s       = 1'b1;
          state_nxt_s         = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_term_s) begin
            adc_start_nxt_s = 1'b1;
            tmo_load_s      = 1'b1;
            state_nxt_s     = S_CONVERT;
          end else begin
            state_nxt_s = S_SETTLE;
          end
        end
        S_CONVERT: begin
          // A done arriving in the expiry cycle still counts as an answer.
          if (adc.adc_done) begin
            acc_nxt_s   = SPIN_SIGN[idx_r] ? (acc_r - sample_s) : (acc_r + sample_s);
            state_nxt_s = S_NEXT;
          end else if (tmo_term_s) begin
            timeout_err_nxt_s = 1'b1;
            phases_nxt_s      = PHASE_IDLE;
            state_nxt_s       = S_IDLE;
          end else begin
            state_nxt_s = S_CONVERT;
          end
        end
        S_NEXT: begin
          if (idx_r == 2'd3) begin
            state_nxt_s = S_DONE;
          end else begin
            idx_nxt_s   = idx_r + 2'd1;
            state_nxt_s = S_SWITCH;
          end
        end
        S_DONE: begin
          result_nxt_s       = acc_r;
          result_valid_nxt_s = 1'b1;
          if (continuous) begin
            // Back-to-back cycle: the plate stays biased, phase 3 -> phase 0.
            state_nxt_s = S_SWITCH;
            idx_nxt_s   = 2'd0;
            acc_nxt_s   = {(ADC_W+2){1'b0}};
          end else begin
            phases_nxt_s = PHASE_IDLE;
            state_nxt_s  = S_IDLE;
          end
        end
        default: begin
          phases_nxt_s = PHASE_IDLE;
          state_nxt_s  = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      idx_r           <= 2'd0;
      acc_r           <= {(ADC_W+2){1'b0}};
      enable_q_r      <= 1'b0;
      phases_r        <= PHASE_IDLE;
      phases_update_r <= 1'b0;
      adc_start_r     <= 1'b0;
      result_r        <= {(ADC_W+2){1'b0}};
      result_valid_r  <= 1'b0;
      busy_r          <= 1'b0;
      timeout_err_r   <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      idx_r           <= idx_nxt_s;
      acc_r           <= acc_nxt_s;
      enable_q_r      <= enable;
      phases_r        <= phases_nxt_s;
      phases_update_r <= phases_update_nxt_s;
      adc_start_r     <= adc_start_nxt_s;
      result_r        <= result_nxt_s;
      result_valid_r  <= result_valid_nxt_s;
      busy_r          <= (state_nxt_s != S_IDLE);
      timeout_err_r   <= timeout_err_nxt_s;
    end
  end

  assign phases        = phases_r;
  assign phases_update = phases_update_r;
  assign adc.adc_start = adc_start_r;
  assign result        = result_r;
  assign result_valid  = result_valid_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_hall_spin_ctrl.sv
// Directed self-checking bench for hall_spin_ctrl with a simple ADC model.
module tb_hall_spin_ctrl;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               continuous;
  logic [7:0]         settle_cycles;
  logic [3:0]         phases;
  logic               phases_update;
  logic signed [13:0] result;
  logic               result_valid;
  logic               busy;
  logic               timeout_err;

  logic               model_done;
  logic signed [11:0] model_data;
  logic               inj_done;
  logic signed [11:0] inj_data;
  logic signed [11:0] tab [4];
  logic [3:0]         mute;

  int checks;
  int errors;
  int cyc;
  int rv_cnt;

  hall_spin_ctrl_if #(.ADC_W(12)) adc_if ();

  assign adc_if.adc_done = model_done | inj_done;
  assign adc_if.adc_data = inj_done ? inj_data : model_data;

  hall_spin_ctrl #(.ADC_W(12), .CNT_W(8), .TIMEOUT(200)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .continuous    (continuous),
    .settle_cycles (settle_cycles),
    .phases        (phases),
    .phases_update (phases_update),
    .adc           (adc_if),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count and result pulse count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
  end

  function automatic int ph_idx(input logic [3:0] ph);
    case (ph)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  // ADC model: answers 2 cycles after adc_start unless that phase is muted.
  initial begin
    model_done = 1'b0;
    model_data = 12'sd0;
    forever begin
      @(negedge clk);
      if (adc_if.adc_start && !mute[ph_idx(phases)]) begin
        model_data = tab[ph_idx(phases)];
        @(negedge clk);
        @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return phases_update;
      1:       return adc_if.adc_start;
      2:       return result_valid;
      default: return timeout_err;
    endcase
  endfunction

  // Steps at least one cycle, then waits (bounded) for the selected pulse.
  task automatic wait_for(input int sel, input string tag, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = sig_of(sel);
    end
    check({tag, "_seen"}, {31'd0, seen}, 1);
  endtask

  task automatic toggle_enable();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    int n;
    int c1;
    int rv0;
    logic [3:0] exp_ph;
    checks = 0; errors = 0; cyc = 0; rv_cnt = 0;
    rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; settle_cycles = 8'd3;
    inj_done = 1'b0; inj_data = 12'sd0; mute = 4'b0000;
    tab[0] = 12'sd100; tab[1] = -12'sd20; tab[2] = 12'sd104; tab[3] = -12'sd16;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_phases", phases, 0);
    check("rst_update", phases_update, 0);
    check("rst_start", adc_if.adc_start, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", timeout_err, 0);

    // Single shot, settle 3: expect 100+20+104+16 = 240.
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_for(0, "t1_update", n);
      exp_ph = 4'b0001 << p;
      check("t1_phase", phases, exp_ph);
      wait_for(1, "t1_start", n);
      check("t1_settle", n, 3);
    end
    wait_for(2, "t1_rv", n);
    check("t1_result", result, 240);
    check("t1_phase_idle", phases, 0);
    check("t1_busy_idle", busy, 0);
    @(negedge clk);
    check("t1_rv_pulse", result_valid, 0);
    repeat (10) @(negedge clk);
    check("t1_no_restart", busy, 0);
    check("t1_rv_count", rv_cnt, 1);

    // Abort during SETTLE of phase 1; late done must be ignored.
    toggle_enable();
    wait_for(0, "t4_upd0", n);
    wait_for(1, "t4_start0", n);
    wait_for(0, "t4_upd1", n);
    check("t4_phase1", phases, 2);
    enable = 1'b0;
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_phases", phases, 0);
    inj_data = 12'sd999;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_result_held", result, 240);
    check("t4_rv_count", rv_cnt, 1);
    check("t4_still_idle", busy, 0);

    // Extremes with settle 0: -2048-2047-2048-2047 = -8190.
    settle_cycles = 8'd0;
    tab[0] = -12'sd2048; tab[1] = 12'sd2047; tab[2] = -12'sd2048; tab[3] = 12'sd2047;
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_for(0, "t5_update", n);
      wait_for(1, "t5_start", n);
      check("t5_settle", n, 1);
    end
    wait_for(2, "t5_rv", n);
    check("t5_result", result, -8190);

    // Reset in CONVERT, coinciding with the model's adc_done.
    settle_cycles = 8'd3;
    toggle_enable();
    wait_for(1, "t6_start", n);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("t6_phases", phases, 0);
    check("t6_update", phases_update, 0);
    check("t6_start", adc_if.adc_start, 0);
    check("t6_result", result, 0);
    check("t6_rv", result_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_err", timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous, constant +50: result 0, period 33, phase 8 -> 1 directly.
    tab[0] = 12'sd50; tab[1] = 12'sd50; tab[2] = 12'sd50; tab[3] = 12'sd50;
    continuous = 1'b1;
    enable = 1'b1;
    wait_for(2, "t2_rv1", n);
    c1 = cyc;
    check("t2_result1", result, 0);
    check("t2_phase_hold", phases, 8);
    wait_for(0, "t2_wrap_upd", n);
    check("t2_wrap_gap", n, 1);
    check("t2_wrap_phase", phases, 1);
    check("t2_busy", busy, 1);
    wait_for(2, "t2_rv2", n);
    check("t2_period", cyc - c1, 33);
    check("t2_result2", result, 0);
    enable = 1'b0;
    @(negedge clk);
    check("t2_stop_busy", busy, 0);
    check("t2_stop_phases", phases, 0);

    // Timeout in phase 2: error 200 cycles after adc_start, sticky.
    continuous = 1'b0;
    mute = 4'b0100;
    tab[0] = 12'sd100; tab[1] = -12'sd20; tab[2] = 12'sd104; tab[3] = -12'sd16;
    rv0 = rv_cnt;
    enable = 1'b1;
    for (int p = 0; p < 3; p++) wait_for(1, "t3_start", n);
    check("t3_phase2", phases, 4);
    wait_for(3, "t3_err", n);
    check("t3_err_delay", n, 200);
    check("t3_phases", phases, 0);
    check("t3_busy", busy, 0);
    continuous = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_blocked", busy, 0);
    check("t3_sticky", timeout_err, 1);
    check("t3_no_rv", rv_cnt - rv0, 0);
    enable = 1'b0;
    @(negedge clk);
    check("t3_err_clr", timeout_err, 0);
    continuous = 1'b0;
    mute = 4'b0000;
    enable = 1'b1;
    wait_for(2, "t3_restart_rv", n);
    check("t3_restart_result", result, 240);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
